// File: rtl/pwl_softmax_pkg.sv
// -----------------------------------------------------------------------------
// pwl_softmax_pkg
// Shared definitions for the piecewise-linear softmax normaliser:
//   state_t     - normaliser FSM state encoding
//   DIV_CYCLES  - quotient bits produced by the reciprocal divider (one per cycle)
//   RECIP_NUM   - numerator of the reciprocal, R = floor(RECIP_NUM / S)
//   DIVISOR_W   - divisor width accepted by the divider (covers N_ELEM up to 16)
//   pwl_scale() - x * R >> 8, the per-element normalisation
// -----------------------------------------------------------------------------
package pwl_softmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DIV   = 2'd2,
        EMIT  = 2'd3
    } state_t;

    localparam int          DIV_CYCLES = 16;
    localparam logic [15:0] RECIP_NUM  = 16'd65535;
    localparam int          DIVISOR_W  = 12;

    // x <= S and R <= 65535/S, so x*R <= 65535 and bits [15:8] never overflow.
    function automatic logic [7:0] pwl_scale(input logic [7:0] x, input logic [15:0] r);
        return 8'(({16'd0, x} * {8'd0, r}) >> 8);
    endfunction

endpackage

// File: rtl/pwl_recip_div.sv
// -----------------------------------------------------------------------------
// pwl_recip_div
// Restoring divider computing quotient = floor(RECIP_NUM / divisor), one
// quotient bit per clock, DIV_CYCLES cycles after start. A zero divisor yields 0.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (aborts a division)
//   start     - one-cycle pulse; samples divisor and (re)starts the division
//   divisor   - 12-bit unsigned divisor
//   quotient  - 16-bit result, valid when done pulses and held afterwards
//   done      - one-cycle pulse, DIV_CYCLES+1 cycles after the start edge
// -----------------------------------------------------------------------------
module pwl_recip_div
    import pwl_softmax_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [15:0]          quotient,
    output logic                 done
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 zero_q, zero_d;
    logic [DIVISOR_W-1:0] dvs_q, dvs_d;
    logic [DIVISOR_W-1:0] rem_q, rem_d;
    logic [15:0]          quo_q, quo_d;
    logic [DIVISOR_W:0]   rem_shift;
    logic [DIVISOR_W-1:0] rem_diff;
    logic                 q_bit;

    always_comb begin
        // quo_q doubles as the dividend shift register: its MSB feeds the
        // remainder while the new quotient bit enters at the LSB.
        rem_shift = {rem_q, quo_q[15]};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        // Remainder stays below the divisor, so modulo-2^12 subtraction is exact.
        rem_diff  = rem_shift[DIVISOR_W-1:0] - dvs_q;

        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        zero_d = zero_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        quo_d  = quo_q;

        if (start) begin
            busy_d = 1'b1;
            cnt_d  = CW'(DIV_CYCLES);
            dvs_d  = divisor;
            zero_d = (divisor == '0);
            rem_d  = '0;
            quo_d  = RECIP_NUM;
        end else if (busy_q) begin
            rem_d = q_bit ? rem_diff : rem_shift[DIVISOR_W-1:0];
            quo_d = {quo_q[14:0], q_bit};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
            dvs_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            zero_q <= zero_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

    // A zero divisor would otherwise produce all ones.
    assign quotient = zero_q ? 16'd0 : quo_q;
    assign done     = done_q;

endmodule

// File: rtl/pwl_softmax_norm.sv
// -----------------------------------------------------------------------------
// pwl_softmax_norm
// Collects N_ELEM pseudo-exponent elements, computes R = floor(65535 / sum)
// and streams each element back scaled as (x * R) >> 8 (255 ~ probability 1.0).
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   in_valid/in_ready    - element input handshake, in_data 8-bit unsigned
//   out_valid/out_ready  - normalised output handshake, out_data 8-bit
//   out_last             - only with PWL_SOFTMAX_LAST_EN: marks the final
//                          element of a frame, qualified by out_valid
// Build option: define PWL_SOFTMAX_LAST_EN to add the out_last port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame in progress, waiting for the first element
// ACCUM | collecting elements into the buffer and running sum
// DIV   | reciprocal divider running on the frame sum
// EMIT  | streaming scaled elements in arrival order
// -----------------------------------------------------------------------------
module pwl_softmax_norm
    import pwl_softmax_pkg::*;
#(
    parameter int N_ELEM = 4,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef PWL_SOFTMAX_LAST_EN
    output logic          out_last,
`endif
    output logic [DW-1:0] out_data
);

    localparam int          SW   = DW + $clog2(N_ELEM);
    localparam int          IW   = $clog2(N_ELEM);
    localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);

    state_t          state_q, state_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d, idx_nxt;
    logic [15:0]     r_q, r_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [DW-1:0]   buf_q [N_ELEM];

    logic            accept;
    logic            div_start;
    logic            div_done;
    logic [15:0]     div_quo;
    logic [DIVISOR_W-1:0] div_divisor;

    assign accept  = in_valid && in_ready_q;
    assign idx_nxt = idx_q + IW'(1);

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        r_d         = r_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        div_start   = 1'b0;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    sum_d = sum_q + SW'(in_data);
                    if (idx_q == LAST) begin
                        state_d   = DIV;
                        idx_d     = '0;
                        div_start = 1'b1;
                    end else begin
                        state_d = ACCUM;
                        idx_d   = idx_nxt;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    r_d         = div_quo;
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_data_d  = pwl_scale(buf_q[0], div_quo);
                end
            end
            EMIT: begin
                if (out_valid_q && out_ready) begin
                    if (idx_q == LAST) begin
                        state_d     = IDLE;
                        idx_d       = '0;
                        sum_d       = '0;
                        out_valid_d = 1'b0;
                    end else begin
                        idx_d      = idx_nxt;
                        out_data_d = pwl_scale(buf_q[idx_nxt], r_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == ACCUM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            idx_q       <= '0;
            r_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            r_q         <= r_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[idx_q] <= in_data;
        end
    end

    // The divider samples the sum including the element accepted this cycle.
    assign div_divisor = DIVISOR_W'(sum_d);

    pwl_recip_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .divisor  (div_divisor),
        .quotient (div_quo),
        .done     (div_done)
    );

`ifdef PWL_SOFTMAX_LAST_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == DIV && div_done) begin
            last_d = 1'b0;
        end else if (state_q == EMIT && out_valid_q && out_ready) begin
            last_d = (idx_q != LAST) && (idx_nxt == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign out_last = last_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pwl_softmax_norm.sv
`timescale 1ns/1ps
module tb_pwl_softmax_norm;
    import pwl_softmax_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef PWL_SOFTMAX_LAST_EN
    logic       out_last;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pwl_softmax_norm #(.N_ELEM(4), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PWL_SOFTMAX_LAST_EN
        .out_last  (out_last),
`endif
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [7:0] a, b, c, d, input bit hold);
        logic [7:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            check("in_ready_accept", in_ready, 1);
            tick();
        end
        last_acc = cyc;
        if (hold) begin
            in_data = 8'd99;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'd0;
        end
    endtask

    task automatic wait_first(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, cyc - last_acc, 17);
    endtask

    task automatic recv(input logic [7:0] e0, e1, e2, e3, input bit toggle, input string tag);
        logic [7:0] exp_v [4];
        logic [7:0] held;
        bit         stalled;
        int         k;
        int         guard;
        int         extra;
        exp_v   = '{e0, e1, e2, e3};
        k       = 0;
        guard   = 0;
        stalled = 1'b0;
        held    = 8'd0;
        while (k < 4 && guard < 100) begin
            if (stalled) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_hold"}, out_data, held);
            end
            out_ready = toggle ? ~out_ready : 1'b1;
            stalled   = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check({tag, "_data"}, out_data, exp_v[k]);
`ifdef PWL_SOFTMAX_LAST_EN
                    check({tag, "_last"}, out_last, (k == 3) ? 1 : 0);
`endif
                    if (k == 3) begin
                        in_valid = 1'b0;
                        in_data  = 8'd0;
                    end
                    k++;
                end else begin
                    held    = out_data;
                    stalled = 1'b1;
                end
            end
            tick();
            guard++;
        end
        check({tag, "_handshakes"}, k, 4);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_out_valid_after"}, out_valid, 0);
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) extra++;
            tick();
        end
        check({tag, "_no_extra_output"}, extra, 0);
    endtask

    initial begin
        int seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", dut.sum_q, 0);
        check("rst_r", dut.r_q, 0);
        check("rst_idx", dut.idx_q, 0);

        // 10,20,30,40: S=100, R=655
        send4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
        wait_first("a");
        check("a_sum", dut.sum_q, 100);
        check("a_r", dut.r_q, 655);
        recv(8'd25, 8'd51, 8'd76, 8'd102, 1'b0, "a");

        // 64 x4: S=256, R=255
        send4(8'd64, 8'd64, 8'd64, 8'd64, 1'b0);
        wait_first("b");
        check("b_r", dut.r_q, 255);
        recv(8'd63, 8'd63, 8'd63, 8'd63, 1'b0, "b");

        // all zero: R=0
        send4(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        wait_first("c");
        check("c_r", dut.r_q, 0);
        recv(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, "c");
        check("c_state_idle", dut.state_q, IDLE);
        check("c_sum_clear", dut.sum_q, 0);

        // 0,0,200,0 with out_ready toggling: S=200, R=327
        send4(8'd0, 8'd0, 8'd200, 8'd0, 1'b0);
        wait_first("d");
        check("d_r", dut.r_q, 327);
        recv(8'd0, 8'd0, 8'd255, 8'd0, 1'b1, "d");

        // in_valid held during DIV/EMIT: 50,50,100,50 -> S=250, R=262
        send4(8'd50, 8'd50, 8'd100, 8'd50, 1'b1);
        check("e_in_ready_div", in_ready, 0);
        wait_first("e");
        check("e_in_ready_emit", in_ready, 0);
        recv(8'd51, 8'd51, 8'd102, 8'd51, 1'b0, "e");
        check("e_sum_clear", dut.sum_q, 0);
        check("e_idx_clear", dut.idx_q, 0);
        check("e_state_idle", dut.state_q, IDLE);

        // reset at cycle 8 of DIV
        send4(8'd7, 8'd7, 8'd7, 8'd7, 1'b0);
        repeat (8) tick();
        check("f_in_div", dut.state_q, DIV);
        rst = 1'b1;
        #2;
        check("f_rst_state", dut.state_q, IDLE);
        check("f_rst_out_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        check("f_in_ready_release", in_ready, 1);
        seen_valid = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        check("f_no_out_after_abort", seen_valid, 0);
        send4(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        wait_first("g");
        check("g_r", dut.r_q, 16383);
        recv(8'd63, 8'd63, 8'd63, 8'd63, 1'b0, "g");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
